// File: rtl/dmul_uni_acc.sv
// Unipolar stochastic multiplier: two operands are compared against low-discrepancy
// sequences, ANDed into a product bitstream, and the ones are counted into prod.
module dmul_uni_acc #(
    parameter int WIDTH = 8,
    parameter int CW    = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             en,
    output logic             busy,
    output logic             oC,
    output logic             oValid,
    output logic             done,
    output logic [CW-1:0]    prod
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    stateT            nextState;
    logic [WIDTH-1:0] aBuf;
    logic [WIDTH-1:0] bBuf;
    logic             modeBuf;
    logic [WIDTH-1:0] cntA;
    logic [WIDTH-1:0] cntB;
    logic [WIDTH-1:0] rngA;
    logic [WIDTH-1:0] rngB;
    logic             cmp;
    logic             lastStep;

    function automatic logic [WIDTH-1:0] bitRev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    // Fast mode uses the plain counter for B so the two streams stay decorrelated.
    always_comb begin
        rngA     = bitRev(cntA);
        rngB     = modeBuf ? cntA : bitRev(cntB);
        cmp      = (aBuf > rngA) & (bBuf > rngB);
        lastStep = (&cntA) & (modeBuf | (&cntB));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = RUN;
            RUN:     if (en && lastStep) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Stalls freeze the counters and the accumulator, so en only shifts bits in time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aBuf    <= '0;
            bBuf    <= '0;
            modeBuf <= 1'b0;
            cntA    <= '0;
            cntB    <= '0;
            prod    <= '0;
            oC      <= 1'b0;
            oValid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oValid <= 1'b0;
                    if (start) begin
                        aBuf    <= iA;
                        bBuf    <= iB;
                        modeBuf <= mode;
                        cntA    <= '0;
                        cntB    <= '0;
                        prod    <= '0;
                    end
                end
                RUN: begin
                    if (en) begin
                        oC     <= cmp;
                        oValid <= 1'b1;
                        prod   <= prod + {{(CW-1){1'b0}}, cmp};
                        cntA   <= cntA + 1'b1;
                        if (!modeBuf && (&cntA)) begin
                            cntB <= cntB + 1'b1;
                        end
                    end else begin
                        oValid <= 1'b0;
                    end
                end
                default: begin
                    oValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmul_uni_acc.sv
// Bench for dmul_uni_acc at WIDTH=4: an index-based reference model checked every
// cycle, plus directed runs with hand-computed product counts and timings.
module tb_dmul_uni_acc;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] iA = '0;
    logic [3:0] iB = '0;
    logic       en = 1'b0;
    logic       busy;
    logic       oC;
    logic       oValid;
    logic       done;
    logic [7:0] prod;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    dmul_uni_acc #(.WIDTH(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .iA(iA), .iB(iB),
        .en(en), .busy(busy), .oC(oC), .oValid(oValid), .done(done), .prod(prod)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int rev4(input int v);
        int r = 0;
        int x = v;
        repeat (4) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Bit k of the product stream, straight from the index definition.
    function automatic bit modelBit(input int a, input int b, input bit m, input int k);
        int ra = rev4(k % 16);
        int rb = m ? (k % 16) : rev4(k / 16);
        return (a > ra) && (b > rb);
    endfunction

    int  mState = 0;
    int  mK = 0;
    int  mA = 0;
    int  mB = 0;
    bit  mM = 1'b0;
    int  expProd = 0;
    bit  expC = 1'b0;
    bit  expV = 1'b0;

    always @(posedge clk or posedge rst) begin
        bit b;
        if (rst) begin
            mState  <= 0;
            mK      <= 0;
            expProd <= 0;
            expC    <= 1'b0;
            expV    <= 1'b0;
        end else begin
            case (mState)
                0: begin
                    expV <= 1'b0;
                    if (start) begin
                        mA      <= int'(iA);
                        mB      <= int'(iB);
                        mM      <= mode;
                        mK      <= 0;
                        expProd <= 0;
                        mState  <= 1;
                    end
                end
                1: begin
                    if (en) begin
                        b        = modelBit(mA, mB, mM, mK);
                        expC    <= b;
                        expV    <= 1'b1;
                        expProd <= expProd + int'(b);
                        mK      <= mK + 1;
                        if (mK + 1 == (mM ? 16 : 256)) mState <= 2;
                    end else begin
                        expV <= 1'b0;
                    end
                end
                default: begin
                    expV   <= 1'b0;
                    mState <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        checkOutput("busy", busy, mState != 0);
        checkOutput("done", done, mState == 2);
        checkOutput("oValid", oValid, expV);
        checkOutput("oC", oC, expC);
        checkOutput("prod", prod, expProd);
    end

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b, input logic m,
                                 input bit stall, input bit holdStart,
                                 output int doneCyc, output int nBits,
                                 output logic [255:0] ones, output logic [7:0] finalProd);
        @(posedge clk); #2;
        iA = a; iB = b; mode = m; start = 1'b1; en = 1'b1;
        doneCyc = -1; nBits = 0; ones = '0; finalProd = '0;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(posedge clk); #2;
            if (!holdStart) start = 1'b0;
            en = stall ? (cyc % 2 == 0) : 1'b1;
            #3;
            if (oValid && nBits < 256) begin
                ones[nBits] = oC;
                nBits++;
            end
            if (done) begin
                doneCyc   = cyc;
                finalProd = prod;
                break;
            end
        end
        if (doneCyc < 0) checkOutput("doneTimeout", 1, 0);
    endtask

    int           dc;
    int           nb;
    logic [255:0] ob;
    logic [7:0]   fp;
    bit           seenDone;

    initial begin
        #1 rst = 1'b1;
        #5;
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstOValid", oValid, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstProd", prod, 0);
        checkOutput("rstOC", oC, 0);
        @(posedge clk); #2 rst = 1'b0;

        applyStimulus(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, dc, nb, ob, fp);
        checkOutput("exact15x15Prod", fp, 225);
        checkOutput("exact15x15DoneCyc", dc, 257);
        checkOutput("exact15x15Bits", nb, 256);

        applyStimulus(4'd8, 4'd8, 1'b0, 1'b0, 1'b0, dc, nb, ob, fp);
        checkOutput("exact8x8Prod", fp, 64);

        applyStimulus(4'd0, 4'd15, 1'b0, 1'b0, 1'b0, dc, nb, ob, fp);
        checkOutput("exact0x15Prod", fp, 0);
        checkOutput("exact0x15Ones", ob == '0, 1);
        checkOutput("exact0x15Bits", nb, 256);

        applyStimulus(4'd8, 4'd8, 1'b1, 1'b0, 1'b0, dc, nb, ob, fp);
        checkOutput("fast8x8Prod", fp, 4);
        checkOutput("fast8x8DoneCyc", dc, 17);
        checkOutput("fast8x8Bits", nb, 16);
        checkOutput("fast8x8Pattern", ob[15:0], 16'h0055);

        applyStimulus(4'd15, 4'd15, 1'b1, 1'b0, 1'b0, dc, nb, ob, fp);
        checkOutput("fast15x15Prod", fp, 15);

        applyStimulus(4'd8, 4'd8, 1'b1, 1'b1, 1'b0, dc, nb, ob, fp);
        checkOutput("stallProd", fp, 4);
        checkOutput("stallDoneCyc", dc, 33);
        checkOutput("stallBits", nb, 16);
        checkOutput("stallPattern", ob[15:0], 16'h0055);

        applyStimulus(4'd8, 4'd8, 1'b1, 1'b0, 1'b1, dc, nb, ob, fp);
        checkOutput("holdDoneCyc", dc, 17);
        @(posedge clk); #5;
        checkOutput("holdIdleBusy", busy, 0);
        checkOutput("holdIdleProd", prod, 4);
        @(posedge clk); #5;
        checkOutput("holdRestartBusy", busy, 1);
        checkOutput("holdRestartProd", prod, 0);
        start = 1'b0;
        seenDone = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seenDone = 1'b1;
                break;
            end
        end
        checkOutput("holdSecondDone", seenDone, 1);
        checkOutput("holdSecondProd", prod, 4);

        @(posedge clk); #2;
        iA = 4'd15; iB = 4'd15; mode = 1'b0; start = 1'b1; en = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (99) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstOValid", oValid, 0);
        checkOutput("midRstProd", prod, 0);
        checkOutput("midRstDone", done, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        applyStimulus(4'd15, 4'd15, 1'b0, 1'b0, 1'b0, dc, nb, ob, fp);
        checkOutput("afterRstProd", fp, 225);
        checkOutput("afterRstDoneCyc", dc, 257);

        @(posedge clk); #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dmul_uni_acc.md
# dmul_uni_acc

Parametrised unipolar stochastic multiplier with a start/done handshake and an on-chip ones-counter. It converts two WIDTH-bit unsigned operands into bitstreams, ANDs them to form the product stream, and accumulates the product. It has two modes: exact full-period (2^(2·WIDTH) cycles) and fast single-period (2^WIDTH cycles). It sits between operand registers and unary consumers, and supplies both the raw product bitstream and a binary product count.

## Interface
- WIDTH, default 8: operand width; also the RNG width.
- CW, default 2·WIDTH: product-count width. Must be ≥ 2·WIDTH.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request a new multiplication; sampled only in IDLE.
- mode  in  1  0 = exact (L = 2^(2·WIDTH)), 1 = fast (L = 2^WIDTH); latched on start.
- iA  in  WIDTH  operand A (value A/2^WIDTH); latched on start.
- iB  in  WIDTH  operand B; latched on start.
- en  in  1  stream advance enable; 0 stalls RUN.
- busy  out  1  high in RUN and DONE.
- oC  out  1  product bit, registered.
- oValid  out  1  oC holds a new bit this cycle.
- done  out  1  one-cycle pulse; prod is final.
- prod  out  CW  count of ones emitted in the current/last run.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: busy=0, oC=0, oValid=0, done=0, prod=0. All internal counters and operand buffers are also 0.
- Internal counters:
  - cntA: WIDTH bits, index within the inner period.
  - cntB: WIDTH bits, outer index, used in exact mode only.
- RNG values (van der Corput / Sobol dim 1 ordering):
  - rngA = bitreverse(cntA).
  - Exact mode: rngB = bitreverse(cntB).
  - Fast mode: rngB = cntA, which is un-reversed and so decorrelated from rngA.
- Product bit: cmp = (A_buf > rngA) & (B_buf > rngB). Comparisons are unsigned and strict.
- IDLE:
  - start=1 → latch iA, iB, mode; clear cntA, cntB, prod; go to RUN.
  - start=0 → stay; prod keeps its last value.
- RUN, on each edge with en=1:
  - oC ← cmp, oValid ← 1, prod ← prod + cmp.
  - cntA ← cntA+1, wrapping modulo 2^WIDTH.
  - Exact mode: cntB increments only on the edge where cntA = 2^WIDTH−1.
  - Final step: the step that consumes index L−1 (exact: cntA = cntB = all ones; fast: cntA = all ones). On that edge, go to DONE.
- RUN, en=0: counters, prod and oC hold; oValid ← 0. Stalls do not change the emitted sequence, only when it is emitted.
- DONE: lasts exactly one cycle. done=1 and prod is final. The next edge goes to IDLE unconditionally.
- start is ignored while busy=1, including start asserted in DONE. No queuing.
- Exact-mode result: prod = A·B exactly. Maximum is (2^WIDTH−1)² < 2^CW, so prod cannot overflow.
- Fast-mode result: prod is approximately A·B/2^WIDTH, and prod ≤ 2^WIDTH.
- Asynchronous rst mid-run: immediately return to IDLE with all reset values. No done pulse is emitted. Results are discarded.

## Timing
- Edge E0 samples start in IDLE. busy=1 from the cycle after E0.
- With en held at 1:
  - RUN occupies cycles 1..L.
  - Bit k (k = 0..L−1) is captured at edge E(k+1) and visible on oC with oValid=1 in cycle k+2.
- The last bit (k = L−1) is visible in the DONE cycle, L+1. done=1 in that same cycle, and prod already includes the last bit.
- busy=0 from cycle L+2. The earliest next accepted start is sampled at edge E(L+2).
- Each en=0 cycle in RUN delays all later bits and done by one cycle.
- prod is registered and updates one cycle after the corresponding cmp.

## Test plan
- Exact, WIDTH=4: A=15, B=15, en=1 → 256 oValid bits, done in cycle 257, prod=225.
- Exact, WIDTH=4: A=8, B=8 → prod=64. A=0, B=15 → prod=0 and oC never 1.
- Fast, WIDTH=4: A=8, B=8 → 16 bits, done in cycle 17, prod=4. Ones occur at indices 0, 2, 4, 6. A=15, B=15 → prod=15.
- Stall: fast, A=8, B=8, en toggled 1/0 each cycle:
  - oValid alternates; same 16-bit sequence as the unstalled run.
  - done in cycle 33, prod=4.
- Handshake:
  - start held high through a run → no second run until IDLE.
  - A new start at the first IDLE edge begins a new run and clears prod to 0 on the next cycle.
- Reset: assert rst at cycle 100 of an exact A=15, B=15 run → same cycle: busy=0, oValid=0, prod=0, no done. A fresh run after release yields prod=225.
